// File: rtl/fetch_pc.sv
// rtl/fetch_pc.sv - program counter, run control and cycle counter for the fetch stage
module fetch_pc #(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              start,
  input  logic              halt,
  input  logic              abs_jump,
  input  logic              branch_en,
  input  logic signed [7:0] offset,
  output logic [PC_W-1:0]   pc,
  output logic              running,
  output logic              done,
  output logic [CNT_W-1:0]  cycle_ct
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;

  logic [PC_W-1:0]  off_sext;
  logic [PC_W-1:0]  off_zext;
  logic [PC_W-1:0]  pc_next_run;
  logic [CNT_W-1:0] ct_next_run;

  // Offset extensions: relative branches sign-extend, absolute jumps treat the table value as unsigned.
  always_comb begin
    off_sext = PC_W'(offset);
    off_zext = PC_W'($unsigned(offset));
  end

  // Next pc while running; halt holds pc at the halt instruction's address, adds wrap mod 2^PC_W.
  always_comb begin
    pc_next_run = pc + PC_W'(1);
    if (halt) begin
      pc_next_run = pc;
    end else if (abs_jump) begin
      pc_next_run = off_zext;
    end else if (branch_en) begin
      pc_next_run = pc + off_sext;
    end
  end

  // Cycle counter saturates rather than wrapping so long benchmarks never read as short ones.
  always_comb begin
    ct_next_run = cycle_ct;
    if (cycle_ct != {CNT_W{1'b1}}) begin
      ct_next_run = cycle_ct + CNT_W'(1);
    end
  end

  // Run-control FSM with registered pc, counter and status outputs.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state    <= IDLE;
      pc       <= '0;
      cycle_ct <= '0;
      running  <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          pc <= '0;
          if (start) begin
            state    <= RUN;
            cycle_ct <= '0;
            running  <= 1'b1;
            done     <= 1'b0;
          end
        end
        RUN: begin
          pc       <= pc_next_run;
          cycle_ct <= ct_next_run;
          if (halt) begin
            state   <= DONE;
            running <= 1'b0;
            done    <= 1'b1;
          end
        end
        DONE: begin
          if (start) begin
            state    <= RUN;
            pc       <= '0;
            cycle_ct <= '0;
            running  <= 1'b1;
            done     <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          pc       <= '0;
          cycle_ct <= '0;
          running  <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_pc.sv
// tb/tb_fetch_pc.sv - directed vector bench for fetch_pc
module tb_fetch_pc;

  localparam int PC_W  = 10;
  localparam int CNT_W = 16;

  logic              CLK;
  logic              reset, start, halt, abs_jump, branch_en;
  logic signed [7:0] offset;
  logic [PC_W-1:0]   pc;
  logic              running, done;
  logic [CNT_W-1:0]  cycle_ct;

  logic              s_reset, s_start, s_halt;
  logic [PC_W-1:0]   s_pc;
  logic              s_running, s_done;
  logic [3:0]        s_cycle_ct;

  int checks = 0;
  int errors = 0;

  fetch_pc #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .reset(reset), .start(start), .halt(halt), .abs_jump(abs_jump),
    .branch_en(branch_en), .offset(offset), .pc(pc), .running(running),
    .done(done), .cycle_ct(cycle_ct)
  );

  fetch_pc #(.PC_W(PC_W), .CNT_W(4)) dut_sat (
    .CLK(CLK), .reset(s_reset), .start(s_start), .halt(s_halt), .abs_jump(1'b0),
    .branch_en(1'b0), .offset(8'sd0), .pc(s_pc), .running(s_running),
    .done(s_done), .cycle_ct(s_cycle_ct)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        reset, start, halt, abs_jump, branch_en;
    logic [7:0]  offset;
    int          exp_pc;
    logic        exp_running, exp_done;
    int          exp_ct;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic s, input logic h, input logic a,
                              input logic b, input logic [7:0] o, input int epc,
                              input logic er, input logic ed, input int ect);
    vec_t v;
    v.reset = r; v.start = s; v.halt = h; v.abs_jump = a; v.branch_en = b; v.offset = o;
    v.exp_pc = epc; v.exp_running = er; v.exp_done = ed; v.exp_ct = ect;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic apply(input int idx, input vec_t v);
    reset = v.reset; start = v.start; halt = v.halt; abs_jump = v.abs_jump;
    branch_en = v.branch_en; offset = v.offset;
    @(posedge CLK);
    #1;
    chk($sformatf("v%0d pc", idx), int'(pc), v.exp_pc);
    chk($sformatf("v%0d running", idx), int'(running), int'(v.exp_running));
    chk($sformatf("v%0d done", idx), int'(done), int'(v.exp_done));
    chk($sformatf("v%0d cycle_ct", idx), int'(cycle_ct), v.exp_ct);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; halt = 1'b0; abs_jump = 1'b0; branch_en = 1'b0; offset = 8'sd0;
    s_reset = 1'b1; s_start = 1'b0; s_halt = 1'b0;

    //                r  s  h  a  b  offset   pc    run done ct
    vecs.push_back(mk(1, 0, 0, 0, 0, 8'd0,    0,    0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 8'd0,    0,    0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 8'd5,    0,    0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 8'd0,    0,    1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 8'd0,    1,    1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 8'd0,    2,    1, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 8'd0,    3,    1, 0, 3));
    vecs.push_back(mk(0, 0, 0, 0, 1, 8'hEE,   1009, 1, 0, 4));
    vecs.push_back(mk(0, 0, 0, 1, 0, 8'd20,   20,   1, 0, 5));
    vecs.push_back(mk(0, 0, 0, 0, 1, 8'hF5,   9,    1, 0, 6));
    vecs.push_back(mk(0, 0, 0, 0, 1, 8'd6,    15,   1, 0, 7));
    vecs.push_back(mk(0, 0, 0, 1, 0, 8'd40,   40,   1, 0, 8));
    vecs.push_back(mk(0, 0, 0, 1, 1, 8'd34,   34,   1, 0, 9));
    vecs.push_back(mk(0, 0, 0, 1, 0, 8'd50,   50,   1, 0, 10));
    vecs.push_back(mk(0, 0, 1, 1, 1, 8'd3,    50,   0, 1, 11));
    vecs.push_back(mk(0, 0, 1, 1, 1, 8'd5,    50,   0, 1, 11));
    vecs.push_back(mk(0, 1, 0, 0, 0, 8'd0,    0,    1, 0, 0));
    for (int i = 1; i <= 5; i++)
      vecs.push_back(mk(0, 0, 0, 0, 1, 8'd0,  0,    1, 0, i));
    vecs.push_back(mk(0, 0, 0, 0, 0, 8'd0,    1,    1, 0, 6));
    vecs.push_back(mk(0, 0, 0, 1, 0, 8'hFF,   255,  1, 0, 7));
    vecs.push_back(mk(0, 1, 0, 0, 0, 8'd0,    256,  1, 0, 8));
    vecs.push_back(mk(0, 0, 0, 0, 1, 8'hFF,   255,  1, 0, 9));
    vecs.push_back(mk(0, 0, 0, 1, 0, 8'd77,   77,   1, 0, 10));
    vecs.push_back(mk(1, 0, 0, 0, 0, 8'd0,    0,    0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 8'd9,    0,    0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 8'd0,    0,    1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 8'hFF,   1023, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 8'd0,    0,    1, 0, 2));

    foreach (vecs[i]) apply(i, vecs[i]);

    // Sequential run up to the top address and across the wrap.
    reset = 1'b0; start = 1'b0; halt = 1'b0; abs_jump = 1'b1; branch_en = 1'b0; offset = 8'sd127;
    @(posedge CLK); #1;
    chk("seq abs127", int'(pc), 127);
    abs_jump = 1'b0; branch_en = 1'b1; offset = 8'sd127;
    for (int i = 0; i < 7; i++) begin
      @(posedge CLK); #1;
    end
    chk("seq branch to 1016", int'(pc), 1016);
    branch_en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(posedge CLK); #1;
    end
    chk("seq pc 1023", int'(pc), 1023);
    @(posedge CLK); #1;
    chk("seq wrap to 0", int'(pc), 0);
    chk("seq ct", int'(cycle_ct), 18);

    // Saturating counter on the CNT_W=4 instance.
    s_reset = 1'b1;
    @(posedge CLK); #1;
    chk("sat reset ct", int'(s_cycle_ct), 0);
    s_reset = 1'b0; s_start = 1'b1;
    @(posedge CLK); #1;
    s_start = 1'b0;
    chk("sat running", int'(s_running), 1);
    for (int i = 1; i <= 20; i++) begin
      @(posedge CLK); #1;
      if (i == 15) chk("sat ct at 15", int'(s_cycle_ct), 15);
    end
    chk("sat ct stuck", int'(s_cycle_ct), 15);
    chk("sat pc", int'(s_pc), 20);
    s_halt = 1'b1;
    @(posedge CLK); #1;
    s_halt = 1'b0;
    chk("sat done", int'(s_done), 1);
    chk("sat ct after halt", int'(s_cycle_ct), 15);
    chk("sat pc after halt", int'(s_pc), 20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_pc.md
# fetch_pc

Program counter and fetch sequencer for the single-cycle core. Sits directly downstream of the branch-offset lookup table: it consumes the table's signed 8-bit output as a relative branch offset or absolute jump target, and drives the instruction-memory address every cycle. It also owns the start/halt run control and a cycle counter used for program benchmarking.

## Interface
Parameters:
- PC_W, 10, width of program counter / instruction-memory address
- CNT_W, 16, width of cycle counter

Ports:
- CLK  input  1  single clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; forces IDLE state
- start  input  1  begin program execution at address 0
- halt  input  1  halt instruction decoded this cycle
- abs_jump  input  1  absolute jump request this cycle
- branch_en  input  1  taken relative branch this cycle (condition already resolved upstream)
- offset  input  8 (signed)  lookup-table output: relative offset or absolute target
- pc  output  PC_W  current instruction address (registered)
- running  output  1  high while in RUN
- done  output  1  high while in DONE
- cycle_ct  output  CNT_W  cycles spent in RUN for the current/last program

## Operation
- States: IDLE, RUN, DONE. Encoding free; outputs decoded from registered state only.
- Reset (any state, any cycle, including mid-program): next state IDLE, pc=0, cycle_ct=0, running=0, done=0. Reset overrides all other inputs.
- IDLE: pc holds 0. start=1 -> RUN, pc=0, cycle_ct=0. All other inputs ignored.
- RUN, per cycle, priority halt > abs_jump > branch_en > sequential:
  - halt: -> DONE; pc holds current value (address of halt instruction).
  - abs_jump: pc <= {zero-extend offset[7:0] to PC_W} (offset treated unsigned).
  - branch_en: pc <= pc + sign-extend(offset) to PC_W, modulo 2^PC_W (wraps both directions; 0 - 11 with PC_W=10 -> 1013).
  - none: pc <= pc + 1, wraps 2^PC_W-1 -> 0.
  - offset=0 with branch_en is a legal self-loop; pc holds.
  - cycle_ct increments by 1 every RUN cycle, including the halt cycle; saturates at 2^CNT_W-1 (no wrap).
  - start in RUN ignored.
- DONE: pc and cycle_ct hold; done=1. start=1 -> RUN with pc=0, cycle_ct=0 (restart). halt/abs_jump/branch_en ignored.
- Outside RUN, offset/abs_jump/branch_en have no effect.

## Timing
- pc, cycle_ct, state are registers; a control input sampled at edge N affects pc visible after edge N (zero-bubble, one-cycle update).
- start sampled at edge N -> running=1 after edge N; first instruction fetched at pc=0 in that cycle.
- halt sampled at edge N -> done=1, running=0 after edge N; pc unchanged across that edge.
- Simultaneous halt+abs_jump+branch_en: only halt acts. abs_jump+branch_en: abs_jump wins.
- Reset values: pc=0, running=0, done=0, cycle_ct=0.
- No combinational path from any input to any output.

## Test plan
- Reset then start: assert reset 2 cycles, start 1 cycle -> running=1, pc sequence 0,1,2,3 on following cycles; cycle_ct 1,2,3,...
- Relative branch: at pc=20 branch_en=1, offset=-11 -> pc=9 next cycle; at pc=9 offset=+6 -> pc=15; at pc=3 offset=-18 -> pc=1009 (wrap, PC_W=10).
- Absolute jump and priority: at pc=40 abs_jump=1, branch_en=1, offset=8'd34 -> pc=34; at pc=50 halt=1, abs_jump=1 -> done=1, pc stays 50, cycle_ct frozen.
- Wrap and self-loop: run to pc=1023 sequentially -> pc=0 next; branch_en with offset=0 for 5 cycles -> pc constant, cycle_ct +5.
- Restart and reset mid-run: from DONE assert start -> pc=0, cycle_ct=0, running=1; assert reset while in RUN at pc=77 -> next cycle IDLE, pc=0, running=0, done=0; branch_en in IDLE -> pc stays 0.
- Counter saturation (CNT_W=4 override): run 20 cycles -> cycle_ct sticks at 15.
